// File: rtl/alu_issue_ctrl.sv
// Issue stage in front of the 16-bit ALU: holds operands until the ALU's registered
// flags settle, then captures result and flags for downstream. Optional macro: ALU_ISSUE_CHAIN_EN.
module alu_issue_ctrl #(
  parameter int         WIDTH        = 16,
  parameter logic [2:0] OPCODE_ARITH = 3'd5
) (
  input  logic             iClock,
  input  logic             iResetn,
  input  logic             iInValid,
  output logic             oInReady,
  input  logic [WIDTH-1:0] iInA,
  input  logic [WIDTH-1:0] iInB,
  input  logic [2:0]       iInOpcode,
  input  logic             iInChain,
  output logic [WIDTH-1:0] oAluA,
  output logic [WIDTH-1:0] oAluB,
  output logic [2:0]       oAluOpcode,
  input  logic [WIDTH-1:0] iAluAccumulator,
  input  logic             iAluCarry,
  input  logic             iAluZero,
  output logic             oOutValid,
  input  logic             iOutReady,
  output logic [WIDTH-1:0] oResult,
  output logic             oCarry,
  output logic             oZero,
  output logic             oBusy,
  output logic [1:0]       oDbgState
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // the request side accepts only in IDLE, the response side completes only in RESP.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

`ifdef ALU_ISSUE_CHAIN_EN
  localparam logic CHAIN_ON = 1'b1;
`else
  localparam logic CHAIN_ON = 1'b0;
`endif

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [2:0]       r_alu_op;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_zero;
  logic             w_accept;
  logic             w_capture;
  logic             w_chain_sel;
  logic             w_is_arith;
  logic [WIDTH-1:0] w_a_src;

  assign w_accept    = (r_state == IDLE) && iInValid;
  assign w_capture   = (r_state == CAPT);
  assign w_chain_sel = iInChain & CHAIN_ON;
  // Chaining feeds the last captured result back as operand A.
  assign w_a_src     = w_chain_sel ? r_result : iInA;
  assign w_is_arith  = (r_alu_op >= OPCODE_ARITH);

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (iInValid) w_next_state = EXEC;
      EXEC:    w_next_state = CAPT;
      CAPT:    w_next_state = RESP;
      RESP:    if (iOutReady) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Operands are never cleared after completion so the ALU inputs stay quiet.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= '0;
    end else if (w_accept) begin
      r_alu_a  <= w_a_src;
      r_alu_b  <= iInB;
      r_alu_op <= iInOpcode;
    end
  end

  // Logic ops never report a carry, whatever the ALU flag says.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_capture) begin
      r_result <= iAluAccumulator;
      r_carry  <= w_is_arith ? iAluCarry : 1'b0;
      r_zero   <= iAluZero;
    end
  end

  assign oInReady   = (r_state == IDLE);
  assign oBusy      = (r_state != IDLE);
  assign oOutValid  = (r_state == RESP);
  assign oAluA      = r_alu_a;
  assign oAluB      = r_alu_b;
  assign oAluOpcode = r_alu_op;
  assign oResult    = r_result;
  assign oCarry     = r_carry;
  assign oZero      = r_zero;
  assign oDbgState  = r_state;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with a stub adder ALU; a request-level model predicts
// every response and the operands held on the ALU port.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_chain;
  logic [15:0] in_a, in_b;
  logic [2:0]  in_op;
  logic [15:0] alu_a, alu_b, alu_acc;
  logic [2:0]  alu_op;
  logic        alu_carry, alu_zero;
  logic        out_valid, out_ready;
  logic [15:0] result;
  logic        carry, zero, busy;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [17:0] exp_q[$];
  logic [15:0] m_last, cur_a, cur_b;
  logic [2:0]  cur_op;

`ifdef ALU_ISSUE_CHAIN_EN
  localparam bit CHAIN_ON = 1'b1;
`else
  localparam bit CHAIN_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .iClock(clk), .iResetn(rst_n),
    .iInValid(in_valid), .oInReady(in_ready),
    .iInA(in_a), .iInB(in_b), .iInOpcode(in_op), .iInChain(in_chain),
    .oAluA(alu_a), .oAluB(alu_b), .oAluOpcode(alu_op),
    .iAluAccumulator(alu_acc), .iAluCarry(alu_carry), .iAluZero(alu_zero),
    .oOutValid(out_valid), .iOutReady(out_ready),
    .oResult(result), .oCarry(carry), .oZero(zero),
    .oBusy(busy), .oDbgState(dbg_state)
  );

  // Stub ALU: combinational sum, carry/zero registered like the real ALU.
  logic [16:0] stub_sum;
  assign stub_sum = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_acc  = stub_sum[15:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_carry <= 1'b0;
      alu_zero  <= 1'b0;
    end else begin
      alu_carry <= stub_sum[16];
      alu_zero  <= (stub_sum[15:0] == 16'h0000);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare process: operand hold and every completed response.
  always @(negedge clk) begin
    if (rst_n) begin
      check("alu_a_hold", {16'h0, alu_a}, {16'h0, cur_a});
      check("alu_b_hold", {16'h0, alu_b}, {16'h0, cur_b});
      check("alu_op_hold", {29'h0, alu_op}, {29'h0, cur_op});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", 32'd1, 32'd0);
        end else begin
          logic [17:0] e;
          e = exp_q.pop_front();
          check("resp_result", {16'h0, result}, {16'h0, e[17:2]});
          check("resp_carry", {31'h0, carry}, {31'h0, e[1]});
          check("resp_zero", {31'h0, zero}, {31'h0, e[0]});
        end
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                       input logic chain);
    logic [15:0] ea;
    logic [16:0] s;
    bit ok;
    ok       = 1'b0;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_chain = chain;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        @(posedge clk);
        ea = (chain && CHAIN_ON) ? m_last : a;
        s  = {1'b0, ea} + {1'b0, b};
        exp_q.push_back({s[15:0], (op >= 3'd5) ? s[16] : 1'b0, s[15:0] == 16'h0});
        cur_a  = ea;
        cur_b  = b;
        cur_op = op;
        m_last = s[15:0];
        #1;
        in_valid = 1'b0;
        in_chain = 1'b0;
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      check("issue_timeout", 32'd1, 32'd0);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_resp();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) check("resp_timeout", 32'd1, 32'd0);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("idle_after_take_ready", {31'h0, in_ready}, 32'd1);
    check("idle_after_take_valid", {31'h0, out_valid}, 32'd0);
  endtask

  logic [15:0] vec_a[5] = '{16'h00FF, 16'h8000, 16'h1234, 16'h7FFF, 16'h0000};
  logic [15:0] vec_b[5] = '{16'h0F01, 16'h8000, 16'hEDCC, 16'h0001, 16'h0000};
  logic [2:0]  vec_op[5] = '{3'd0, 3'd7, 3'd1, 3'd6, 3'd3};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_chain = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = '0;
    m_last = '0; cur_a = '0; cur_b = '0; cur_op = '0;
    repeat (2) step();
    check("rst_in_ready", {31'h0, in_ready}, 32'd1);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_result", {16'h0, result}, 32'd0);
    check("rst_flags", {30'h0, carry, zero}, 32'd0);
    rst_n = 1'b1;
    step();

    // Arithmetic op with latency pinned by hand.
    issue(16'h0003, 16'h0004, 3'b101, 1'b0);
    check("lat_exec_busy", {31'h0, busy}, 32'd1);
    check("lat_exec_valid", {31'h0, out_valid}, 32'd0);
    step();
    check("lat_capt_valid", {31'h0, out_valid}, 32'd0);
    step();
    check("lat_resp_valid", {31'h0, out_valid}, 32'd1);
    check("arith_result", {16'h0, result}, 32'h0007);
    check("arith_flags", {30'h0, carry, zero}, 32'd0);
    consume();

    // Carry reported for arithmetic, masked for logic opcodes.
    issue(16'hFFFF, 16'h0001, 3'b101, 1'b0);
    wait_resp();
    check("carry_arith_c", {31'h0, carry}, 32'd1);
    check("carry_arith_z", {31'h0, zero}, 32'd1);
    check("carry_arith_r", {16'h0, result}, 32'h0000);
    consume();
    issue(16'hFFFF, 16'h0001, 3'b010, 1'b0);
    wait_resp();
    check("carry_logic_c", {31'h0, carry}, 32'd0);
    check("carry_logic_z", {31'h0, zero}, 32'd1);
    consume();

    for (int i = 0; i < 5; i++) begin
      issue(vec_a[i], vec_b[i], vec_op[i], 1'b0);
      wait_resp();
      consume();
    end

    // Backpressure with a competing request held during RESP.
    issue(16'h1111, 16'h2222, 3'd6, 1'b0);
    wait_resp();
    in_a = 16'hAAAA; in_b = 16'h5555; in_op = 3'd5; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'h0, out_valid}, 32'd1);
      check("bp_result", {16'h0, result}, 32'h3333);
      check("bp_in_ready", {31'h0, in_ready}, 32'd0);
      step();
    end
    consume();
    check("bp_not_accepted", {16'h0, alu_a}, 32'h1111);
    issue(16'hAAAA, 16'h5555, 3'd5, 1'b0);
    wait_resp();
    check("bp_next_result", {16'h0, result}, 32'hFFFF);
    consume();

    // Chaining.
    issue(16'h0003, 16'h0004, 3'd5, 1'b0);
    wait_resp();
    consume();
    issue(16'h1234, 16'h0001, 3'd5, 1'b1);
    check("chain_alu_a", {16'h0, alu_a}, CHAIN_ON ? 32'h0007 : 32'h1234);
    check("chain_alu_b", {16'h0, alu_b}, 32'h0001);
    wait_resp();
    consume();

    // Reset in the middle of EXEC.
    issue(16'h0101, 16'h0202, 3'd5, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    m_last = '0; cur_a = '0; cur_b = '0; cur_op = '0;
    check("arst_busy", {31'h0, busy}, 32'd0);
    check("arst_out_valid", {31'h0, out_valid}, 32'd0);
    check("arst_alu_a", {16'h0, alu_a}, 32'd0);
    check("arst_result", {16'h0, result}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("arst_in_ready", {31'h0, in_ready}, 32'd1);
    issue(16'h0002, 16'h0003, 3'd5, 1'b0);
    wait_resp();
    check("post_rst_result", {16'h0, result}, 32'h0005);
    consume();

    step();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
